switch_allocator_wf: RTL and testbench
======================================

// Module: switch_allocator_wf
// PURPOSE
//  Wormhole switch allocator for the 5-port mesh router. Sits after route computation: takes per-input
//  {port,vc} routes plus flit types, arbitrates each output port round-robin among head flits, then locks
//  the output to the winning input until its tail flit passes. Drives input-buffer pop grants and crossbar selects.
// PARAMETERS
//  NPORTS       5    ports; index 0=N,1=E,2=S,3=W,4=Local (matches route port code); fixed at 5
//  STALL_LIMIT  255  idle cycles of a lock owner before err_stall is raised
//  STALL_W      8    width of per-output stall counter; must hold STALL_LIMIT
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   reset, asynchronous, active-high
//  req_valid      in   5   input i holds a flit at buffer head
//  req_route      in   25  input i route {port[2:0],vc[1:0]} at [i*5+:5]
//  req_flit_type  in   15  input i flit type at [i*3+:3]; 000 head, 001 body, 010 tail
//  out_ready      in   5   output o can accept a flit this cycle
//  grant          out  5   input i flit transfers at this posedge (pop)
//  out_valid      out  5   output o carries a flit this cycle
//  xbar_sel       out  15  output o source input index at [o*3+:3]
//  out_vc         out  10  output o VC at [o*2+:2]
//  out_locked     out  5   output o currently owned by a packet
//  err_orphan     out  1   sticky: body/tail requested an unlocked output or a non-owner-held output
//  err_bad_port   out  1   sticky: route port code 101..111 requested
//  err_stall      out  1   sticky: lock owner idle for STALL_LIMIT cycles
// BEHAVIOUR
//  - State per output o: lock (IDLE/LOCKED), owner[2:0], lvc[1:0], rr_ptr[2:0], stall_cnt[STALL_W-1:0].
//  - Reset: all IDLE, owner=0, lvc=0, rr_ptr=0, stall_cnt=0, errors=0; grant/out_valid forced 0 while rst=1.
//  - Zero-latency allocation: grant, out_valid, xbar_sel, out_vc are combinational from state + inputs;
//    state updates at posedge. Input pops on any posedge where grant[i]=1.
//  - Each input targets exactly one output (its route port), so no input-side conflict.
//  - IDLE output o: eligible = inputs with req_valid, port==o, type==head. Round-robin search from
//    rr_ptr[o] upward mod 5; winner w granted iff out_ready[o]. On grant: LOCKED, owner=w, lvc=route vc,
//    rr_ptr=(w+1) mod 5. out_vc = winner route vc.
//  - LOCKED output o: only owner eligible, type body or tail; granted iff req_valid & out_ready[o].
//    out_vc=lvc, xbar_sel=owner. Tail grant -> IDLE at that edge; a new head may win the next cycle.
//  - Head from owner while LOCKED: not granted, sets err_orphan. Body/tail to IDLE output or from non-owner:
//    never granted, sets err_orphan. Port code >4: never granted, sets err_bad_port.
//  - out_ready=0: no grant, no state change, rr_ptr unchanged.
//  - stall_cnt[o]: clears on grant or IDLE; +1 each cycle LOCKED and owner not requesting o; saturates;
//    reaching STALL_LIMIT sets err_stall. Lock is never broken by stall.
//  - xbar_sel/out_vc are 0 when out_valid[o]=0.
//  - Reset mid-packet: locks dropped immediately; remaining body/tail flits then flag err_orphan.
//  - Error flags clear only on rst.
// STRUCTURE
//  - Shared package: port codes (N/E/S/W/LOCAL), flit type codes, route field slices, NPORTS.
//  - One sub-module: rr_arbiter5 (5-bit req + 3-bit ptr -> one-hot grant + index), instantiated per output.
//  - Top holds lock FSM, stall counters, error flags, output muxing.
// TESTING
//  1. In0 and In3 heads -> E (port 001), rr_ptr[E]=0, out_ready=1 -> grant=00001, xbar_sel[E]=0,
//     E locked; In3 waits until In0 tail granted, In3 head granted the next cycle, rr_ptr[E]=1 then 4.
//  2. E locked to In0, out_ready[E]=0 for 3 cycles -> grant[0]=0, out_valid[E]=0, lock held; resumes on ready.
//  3. Local body flit -> S while S IDLE -> grant=0, err_orphan=1 and stays 1.
//  4. Owner holds lock, no request for 255 cycles -> err_stall=1 on the 255th idle cycle; out_locked still 1.
//  5. All 5 inputs send head+tail packets -> Local continuously -> head grant order 0,1,2,3,4,0...
//  6. rst pulsed mid-packet -> out_locked=0 asynchronously; next body flit -> no grant, err_orphan=1.
//  7. Head with port 101 -> no grant on any output, err_bad_port=1.

Source files
------------

// File: rtl/switch_allocator_wf_pkg.sv
// Shared definitions for the wormhole switch allocator:
// port and flit codes, lock states and route field helpers.
package switch_allocator_wf_pkg;

    localparam int NPORTS = 5;

    localparam logic [2:0] PORT_N     = 3'd0;
    localparam logic [2:0] PORT_E     = 3'd1;
    localparam logic [2:0] PORT_S     = 3'd2;
    localparam logic [2:0] PORT_W     = 3'd3;
    localparam logic [2:0] PORT_LOCAL = 3'd4;

    localparam logic [2:0] FT_HEAD = 3'b000;
    localparam logic [2:0] FT_BODY = 3'b001;
    localparam logic [2:0] FT_TAIL = 3'b010;

    typedef enum logic {
        L_IDLE,
        L_LOCKED
    } lock_e;

    function automatic logic [2:0] rt_port(input logic [24:0] r,
                                           input int i);
        return r[i*5+2 +: 3];
    endfunction

    function automatic logic [1:0] rt_vc(input logic [24:0] r,
                                         input int i);
        return r[i*5 +: 2];
    endfunction

    function automatic logic [2:0] ft_of(input logic [14:0] t,
                                         input int i);
        return t[i*3 +: 3];
    endfunction

    function automatic logic [2:0] next_ptr(input logic [2:0] w);
        return (w >= 3'd4) ? 3'd0 : 3'(w + 3'd1);
    endfunction

endpackage

// File: rtl/switch_allocator_wf_if.sv
// Request/grant bundle between input buffers, allocator
// and crossbar; master drives requests, slave allocates.
interface switch_allocator_wf_if;

    logic [4:0]  req_valid;
    logic [24:0] req_route;
    logic [14:0] req_flit_type;
    logic [4:0]  out_ready;
    logic [4:0]  grant;
    logic [4:0]  out_valid;
    logic [14:0] xbar_sel;
    logic [9:0]  out_vc;
    logic [4:0]  out_locked;
    logic        err_orphan;
    logic        err_bad_port;
    logic        err_stall;

    modport master (
        output req_valid, req_route, req_flit_type, out_ready,
        input  grant, out_valid, xbar_sel, out_vc, out_locked,
        input  err_orphan, err_bad_port, err_stall
    );

    modport slave (
        input  req_valid, req_route, req_flit_type, out_ready,
        output grant, out_valid, xbar_sel, out_vc, out_locked,
        output err_orphan, err_bad_port, err_stall
    );

endinterface

// File: rtl/switch_allocator_wf_rr_arbiter5.sv
// Five-way round-robin arbiter: first requester found
// searching upward from ptr_i, wrapping modulo five.
module rr_arbiter5 (
    input  logic [4:0] req_i,
    input  logic [2:0] ptr_i,
    output logic [4:0] gnt_o,
    output logic [2:0] idx_o,
    output logic       any_o
);

    int c;

    // scan five candidates starting at the pointer
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        c     = 0;
        for (int k = 0; k < 5; k++) begin
            c = (int'(ptr_i) + k) % 5;
            if (!any_o && req_i[c]) begin
                any_o    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = 3'(c);
            end
        end
    end

endmodule

// File: rtl/switch_allocator_wf.sv
// Wormhole switch allocator: round-robin head arbitration
// per output, lock held by the winner until its tail.
module switch_allocator_wf
    import switch_allocator_wf_pkg::*;
#(
    parameter int STALL_LIMIT = 255,
    parameter int STALL_W     = 8
) (
    input logic                 clk,
    input logic                 rst,
    switch_allocator_wf_if.slave bus
);

    lock_e              lock_q  [NPORTS];
    lock_e              lock_d  [NPORTS];
    logic [2:0]         owner_q [NPORTS];
    logic [2:0]         owner_d [NPORTS];
    logic [1:0]         lvc_q   [NPORTS];
    logic [1:0]         lvc_d   [NPORTS];
    logic [2:0]         rr_q    [NPORTS];
    logic [2:0]         rr_d    [NPORTS];
    logic [STALL_W-1:0] stall_q [NPORTS];
    logic [STALL_W-1:0] stall_d [NPORTS];

    logic orphan_q, orphan_d;
    logic badp_q, badp_d;
    logic stall_err_q, stall_err_d;

    logic [4:0] head_req [NPORTS];
    logic [4:0] arb_gnt  [NPORTS];
    logic [2:0] arb_idx  [NPORTS];
    logic [4:0] arb_any;

    logic [4:0] o_gnt;
    logic [2:0] o_sel [NPORTS];
    logic [1:0] o_vc  [NPORTS];
    logic [4:0] own_req;
    logic [4:0] in_gnt;
    logic [2:0] ow;
    logic [2:0] p;
    logic [2:0] t;

    // head flits eligible for each output's arbiter
    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            head_req[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                head_req[o][i] = bus.req_valid[i] &&
                    rt_port(bus.req_route, i) == 3'(o) &&
                    ft_of(bus.req_flit_type, i) == FT_HEAD;
            end
        end
    end

    for (genvar g = 0; g < NPORTS; g++) begin : g_arb
        rr_arbiter5 u_arb (
            .req_i (head_req[g]),
            .ptr_i (rr_q[g]),
            .gnt_o (arb_gnt[g]),
            .idx_o (arb_idx[g]),
            .any_o (arb_any[g])
        );
    end

    // grant selection: arbiter when idle, owner when locked
    always_comb begin
        in_gnt  = '0;
        o_gnt   = '0;
        own_req = '0;
        ow      = '0;
        for (int o = 0; o < NPORTS; o++) begin
            o_sel[o] = '0;
            o_vc[o]  = '0;
            if (lock_q[o] == L_IDLE) begin
                if (arb_any[o] && bus.out_ready[o] && !rst) begin
                    o_gnt[o] = 1'b1;
                    o_sel[o] = arb_idx[o];
                    o_vc[o]  = rt_vc(bus.req_route, int'(arb_idx[o]));
                    in_gnt   = in_gnt | arb_gnt[o];
                end
            end else begin
                ow = owner_q[o];
                own_req[o] = bus.req_valid[ow] &&
                    rt_port(bus.req_route, int'(ow)) == 3'(o) &&
                    (ft_of(bus.req_flit_type, int'(ow)) == FT_BODY ||
                     ft_of(bus.req_flit_type, int'(ow)) == FT_TAIL);
                if (own_req[o] && bus.out_ready[o] && !rst) begin
                    o_gnt[o]   = 1'b1;
                    o_sel[o]   = ow;
                    o_vc[o]    = lvc_q[o];
                    in_gnt[ow] = 1'b1;
                end
            end
        end
    end

    // pack per-output selects onto the flat buses
    always_comb begin
        bus.xbar_sel   = '0;
        bus.out_vc     = '0;
        bus.out_locked = '0;
        for (int o = 0; o < NPORTS; o++) begin
            bus.xbar_sel[o*3 +: 3] = o_sel[o];
            bus.out_vc[o*2 +: 2]   = o_vc[o];
            bus.out_locked[o]      = (lock_q[o] == L_LOCKED);
        end
    end

    assign bus.grant        = in_gnt;
    assign bus.out_valid    = o_gnt;
    assign bus.err_orphan   = orphan_q;
    assign bus.err_bad_port = badp_q;
    assign bus.err_stall    = stall_err_q;

    // next lock, pointer, stall and error state
    always_comb begin
        orphan_d    = orphan_q;
        badp_d      = badp_q;
        stall_err_d = stall_err_q;
        p           = '0;
        t           = '0;
        for (int i = 0; i < NPORTS; i++) begin
            p = rt_port(bus.req_route, i);
            t = ft_of(bus.req_flit_type, i);
            if (bus.req_valid[i]) begin
                if (p > PORT_LOCAL) begin
                    badp_d = 1'b1;
                end else if (t == FT_BODY || t == FT_TAIL) begin
                    if (lock_q[p] == L_IDLE || owner_q[p] != 3'(i))
                        orphan_d = 1'b1;
                end else if (t == FT_HEAD) begin
                    if (lock_q[p] == L_LOCKED && owner_q[p] == 3'(i))
                        orphan_d = 1'b1;
                end
            end
        end
        for (int o = 0; o < NPORTS; o++) begin
            lock_d[o]  = lock_q[o];
            owner_d[o] = owner_q[o];
            lvc_d[o]   = lvc_q[o];
            rr_d[o]    = rr_q[o];
            stall_d[o] = stall_q[o];
            if (o_gnt[o]) begin
                stall_d[o] = '0;
                if (lock_q[o] == L_IDLE) begin
                    lock_d[o]  = L_LOCKED;
                    owner_d[o] = o_sel[o];
                    lvc_d[o]   = o_vc[o];
                    rr_d[o]    = next_ptr(o_sel[o]);
                end else if (ft_of(bus.req_flit_type,
                                   int'(owner_q[o])) == FT_TAIL) begin
                    lock_d[o] = L_IDLE;
                end
            end else if (lock_q[o] == L_IDLE) begin
                stall_d[o] = '0;
            end else if (!own_req[o]) begin
                if (stall_q[o] != '1)
                    stall_d[o] = stall_q[o] + 1'b1;
                if (stall_d[o] == STALL_W'(STALL_LIMIT))
                    stall_err_d = 1'b1;
            end
        end
    end

    // state registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NPORTS; o++) begin
                lock_q[o]  <= L_IDLE;
                owner_q[o] <= '0;
                lvc_q[o]   <= '0;
                rr_q[o]    <= '0;
                stall_q[o] <= '0;
            end
            orphan_q    <= 1'b0;
            badp_q      <= 1'b0;
            stall_err_q <= 1'b0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                lock_q[o]  <= lock_d[o];
                owner_q[o] <= owner_d[o];
                lvc_q[o]   <= lvc_d[o];
                rr_q[o]    <= rr_d[o];
                stall_q[o] <= stall_d[o];
            end
            orphan_q    <= orphan_d;
            badp_q      <= badp_d;
            stall_err_q <= stall_err_d;
        end
    end

endmodule

// File: tb/tb_switch_allocator_wf.sv
// Directed bench for the wormhole switch allocator with
// hand-computed grants, selects and error flags.
module tb_switch_allocator_wf;

    localparam logic [2:0] HD = 3'b000;
    localparam logic [2:0] BD = 3'b001;
    localparam logic [2:0] TL = 3'b010;

    logic clk;
    logic rst;
    int   n_asr;
    int   n_fail;

    switch_allocator_wf_if bus ();

    switch_allocator_wf dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asr++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int i, input logic [2:0] p,
                       input logic [1:0] vc, input logic [2:0] t);
        bus.req_valid[i]          = 1'b1;
        bus.req_route[i*5 +: 5]   = {p, vc};
        bus.req_flit_type[i*3 +: 3] = t;
    endtask

    task automatic drop(input int i);
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int order [6];
        logic [4:0] pend;
        n_asr  = 0;
        n_fail = 0;
        order  = '{0, 1, 2, 3, 4, 0};
        pend   = '0;
        rst = 1'b1;
        bus.req_valid     = '0;
        bus.req_route     = '0;
        bus.req_flit_type = '0;
        bus.out_ready     = 5'b11111;

        // reset state, grant forced low
        put(0, 3'd1, 2'd0, HD);
        cyc();
        chk("rst_grant", bus.grant, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_locked", bus.out_locked, 0);
        chk("rst_errs", {bus.err_orphan, bus.err_bad_port,
                         bus.err_stall}, 0);
        drop(0);
        rst = 1'b0;
        cyc();

        // In0 and In3 heads to E
        put(0, 3'd1, 2'd2, HD);
        put(3, 3'd1, 2'd1, HD);
        #1;
        chk("t1_grant", bus.grant, 5'b00001);
        chk("t1_oval", bus.out_valid, 5'b00010);
        chk("t1_xsel", bus.xbar_sel, 0);
        chk("t1_ovc", bus.out_vc, 10'h008);
        cyc();
        chk("t1_lock", bus.out_locked, 5'b00010);
        put(0, 3'd1, 2'd2, BD);
        #1;
        chk("t1_body", bus.grant, 5'b00001);
        chk("t1_bvc", bus.out_vc, 10'h008);
        cyc();

        // backpressure on E for three cycles
        bus.out_ready[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t2_grant", bus.grant, 0);
            chk("t2_oval", bus.out_valid, 0);
            cyc();
            chk("t2_lock", bus.out_locked, 5'b00010);
        end
        bus.out_ready[1] = 1'b1;
        #1;
        chk("t2_resume", bus.grant, 5'b00001);
        cyc();
        put(0, 3'd1, 2'd2, TL);
        #1;
        chk("t1_tail", bus.grant, 5'b00001);
        cyc();
        chk("t1_unlock", bus.out_locked, 0);
        drop(0);
        #1;
        chk("t1_in3", bus.grant, 5'b01000);
        chk("t1_in3sel", bus.xbar_sel, 15'd24);
        chk("t1_in3vc", bus.out_vc, 10'h004);
        cyc();
        put(3, 3'd1, 2'd1, TL);
        #1;
        chk("t1_in3tl", bus.grant, 5'b01000);
        cyc();

        // pointer now 4: In4 beats In3
        put(3, 3'd1, 2'd1, HD);
        put(4, 3'd1, 2'd0, HD);
        #1;
        chk("rr_in4", bus.grant, 5'b10000);
        chk("rr_in4sel", bus.xbar_sel, 15'd32);
        cyc();
        put(4, 3'd1, 2'd0, TL);
        #1;
        chk("rr_in4tl", bus.grant, 5'b10000);
        cyc();
        drop(4);
        #1;
        chk("rr_in3", bus.grant, 5'b01000);
        cyc();
        put(3, 3'd1, 2'd1, TL);
        #1;
        chk("rr_in3tl", bus.grant, 5'b01000);
        cyc();
        drop(3);
        chk("no_orphan", bus.err_orphan, 0);

        // Local body to idle S
        put(4, 3'd2, 2'd0, BD);
        #1;
        chk("t3_grant", bus.grant, 0);
        cyc();
        chk("t3_orph", bus.err_orphan, 1);
        drop(4);
        cyc();
        chk("t3_sticky", bus.err_orphan, 1);

        // bad port code
        put(1, 3'd5, 2'd0, HD);
        #1;
        chk("t7_grant", bus.grant, 0);
        chk("t7_oval", bus.out_valid, 0);
        cyc();
        chk("t7_bad", bus.err_bad_port, 1);
        drop(1);
        cyc();

        // all inputs stream head+tail to Local
        for (int k = 0; k < 6; k++) begin
            for (int h = 0; h < 2; h++) begin
                for (int i = 0; i < 5; i++)
                    put(i, 3'd4, 2'(i), pend[i] ? TL : HD);
                #1;
                chk("t5_grant", bus.grant, 5'b1 << order[k]);
                chk("t5_xsel", bus.xbar_sel[14:12], order[k]);
                cyc();
                pend[order[k]] = ~pend[order[k]];
            end
        end
        for (int i = 0; i < 5; i++)
            drop(i);
        cyc();

        // stall: owner idles after head
        put(2, 3'd0, 2'd3, HD);
        #1;
        chk("t4_grant", bus.grant, 5'b00100);
        chk("t4_ovc", bus.out_vc, 10'h003);
        cyc();
        drop(2);
        repeat (254) cyc();
        chk("t4_nostall", bus.err_stall, 0);
        cyc();
        chk("t4_stall", bus.err_stall, 1);
        chk("t4_lock", bus.out_locked[0], 1);
        put(2, 3'd0, 2'd3, TL);
        #1;
        chk("t4_tail", bus.grant, 5'b00100);
        cyc();
        drop(2);
        chk("t4_unlock", bus.out_locked, 0);

        // reset in the middle of a packet on W
        put(1, 3'd3, 2'd1, HD);
        #1;
        chk("t6_head", bus.grant, 5'b00010);
        cyc();
        put(1, 3'd3, 2'd1, BD);
        #1;
        chk("t6_body", bus.grant, 5'b00010);
        rst = 1'b1;
        #1;
        chk("t6_unlock", bus.out_locked, 0);
        chk("t6_rgrant", bus.grant, 0);
        chk("t6_rerr", {bus.err_orphan, bus.err_stall}, 0);
        rst = 1'b0;
        #1;
        chk("t6_nogrant", bus.grant, 0);
        cyc();
        chk("t6_orph", bus.err_orphan, 1);
        drop(1);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asr, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
